// File: rtl/trace_tx.sv
// Retire-trace transmitter: captures WB retire records into a FIFO and
// serializes each one as a fixed 9-byte packet on a valid/ready byte stream.
module trace_tx #(
    parameter int PC_W   = 24,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 8
) (
    input  logic                     iw_clk,
    input  logic                     iw_rst,
    input  logic                     iw_en,
    input  logic                     iw_wb_valid,
    input  logic [PC_W-1:0]          iw_wb_pc,
    input  logic [7:0]               iw_wb_opc,
    input  logic                     iw_wb_wr_en,
    input  logic [3:0]               iw_wb_tgt_gp,
    input  logic [DATA_W-1:0]        iw_wb_result,
    output logic [7:0]               ow_tx_data,
    output logic                     ow_tx_valid,
    input  logic                     iw_tx_ready,
    output logic                     ow_busy,
    output logic [$clog2(DEPTH):0]   ow_fifo_level,
    output logic [7:0]               ow_drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [7:0]        opc;
        logic              wr_en;
        logic [3:0]        tgt;
        logic [DATA_W-1:0] res;
    } rec_t;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    rec_t          mem [DEPTH];
    rec_t          rec_in;
    rec_t          shadow;
    logic          shadow_lost;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [LW-1:0] level_d;
    logic          lost;
    logic [7:0]    drop_cnt;
    logic          busy_q;
    state_t        state;
    state_t        state_d;
    logic [3:0]    idx;
    logic [3:0]    idx_d;
    logic          pop;
    logic          push_req;
    logic          full;
    logic          push;
    logic          drop;
    logic [7:0]    tx_byte;

    assign rec_in   = '{pc: iw_wb_pc, opc: iw_wb_opc, wr_en: iw_wb_wr_en,
                        tgt: iw_wb_tgt_gp, res: iw_wb_result};
    assign push_req = iw_en & iw_wb_valid;
    assign full     = (level == LW'(DEPTH));
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // Occupancy after this edge; a simultaneous push and pop cancel out.
    always_comb begin
        level_d = level;
        if (push && !pop) level_d = level + LW'(1);
        else if (pop && !push) level_d = level - LW'(1);
    end

    // FIFO storage; contents are don't-care once pointers reset.
    always_ff @(posedge iw_clk) begin
        if (push) mem[wr_ptr] <= rec_in;
    end

    // Pointers, occupancy, drop counter, sticky lost flag and busy.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
            lost     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level_d;
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            if (drop) lost <= 1'b1;
            else if (pop) lost <= 1'b0;
            busy_q <= (state_d == SEND) | (level_d != '0);
        end
    end

    // Shadow copy of the packet in flight, loaded only on a pop.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            shadow      <= '0;
            shadow_lost <= 1'b0;
        end else if (pop) begin
            shadow      <= mem[rd_ptr];
            shadow_lost <= lost;
        end
    end

    // FSM state and byte index register.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    // Next state: pop when idle, or chain the next packet after B8.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (level != '0) begin
                    pop     = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (iw_tx_ready) begin
                    if (idx == 4'd8) begin
                        idx_d = '0;
                        if (level != '0) pop = 1'b1;
                        else state_d = IDLE;
                    end else begin
                        idx_d = idx + 4'd1;
                    end
                end
            end
        endcase
    end

    // Byte select from the shadow; zero whenever nothing is in flight.
    always_comb begin
        tx_byte = 8'h00;
        if (state == SEND) begin
            unique case (idx)
                4'd0:    tx_byte = 8'hA5;
                4'd1:    tx_byte = shadow.opc;
                4'd2:    tx_byte = {shadow.wr_en, shadow_lost, 2'b00, shadow.tgt};
                4'd3:    tx_byte = shadow.pc[7:0];
                4'd4:    tx_byte = shadow.pc[15:8];
                4'd5:    tx_byte = shadow.pc[23:16];
                4'd6:    tx_byte = shadow.res[7:0];
                4'd7:    tx_byte = shadow.res[15:8];
                4'd8:    tx_byte = shadow.res[23:16];
                default: tx_byte = 8'h00;
            endcase
        end
    end

    assign ow_tx_data    = tx_byte;
    assign ow_tx_valid   = (state == SEND);
    assign ow_busy       = busy_q;
    assign ow_fifo_level = level;
    assign ow_drop_cnt   = drop_cnt;

endmodule

// File: tb/tb_trace_tx.sv
// Bench for trace_tx: queue-based reference model of the retire FIFO and
// packet stream, directed scenarios followed by randomized traffic.
module tb_trace_tx;

    localparam int DEPTH = 8;

    typedef struct {
        logic [23:0] pc;
        logic [7:0]  opc;
        logic        wr;
        logic [3:0]  tgt;
        logic [23:0] res;
    } trec_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic                   wb_valid;
    logic [23:0]            wb_pc;
    logic [7:0]             wb_opc;
    logic                   wb_wr;
    logic [3:0]             wb_tgt;
    logic [23:0]            wb_res;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [7:0]             drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    trec_t      q[$];
    logic [7:0] pkt[$];
    logic [7:0] seen[$];
    bit         m_lost;
    int         m_drop;
    int         peak;
    logic [7:0] exp1 [9];

    trace_tx #(.PC_W(24), .DATA_W(24), .DEPTH(DEPTH)) dut (
        .iw_clk        (clk),
        .iw_rst        (rst),
        .iw_en         (en),
        .iw_wb_valid   (wb_valid),
        .iw_wb_pc      (wb_pc),
        .iw_wb_opc     (wb_opc),
        .iw_wb_wr_en   (wb_wr),
        .iw_wb_tgt_gp  (wb_tgt),
        .iw_wb_result  (wb_res),
        .ow_tx_data    (tx_data),
        .ow_tx_valid   (tx_valid),
        .iw_tx_ready   (tx_ready),
        .ow_busy       (busy),
        .ow_fifo_level (fifo_level),
        .ow_drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit busy_m();
        return (pkt.size() > 0) || (q.size() > 0);
    endfunction

    // One clock: advance the model by the spec rules, then compare at negedge.
    task automatic step();
        trec_t r;
        bit was_idle, acc, popn, preq, drp;
        if (tx_valid && tx_ready) seen.push_back(tx_data);
        @(posedge clk);
        if (rst) begin
            q.delete();
            pkt.delete();
            m_lost = 0;
            m_drop = 0;
        end else begin
            was_idle = (pkt.size() == 0);
            acc      = !was_idle && tx_ready;
            if (acc) pkt.delete(0);
            popn = (q.size() > 0) && (was_idle || (acc && pkt.size() == 0));
            preq = en && wb_valid;
            drp  = preq && (q.size() == DEPTH) && !popn;
            if (popn) begin
                r = q.pop_front();
                pkt.push_back(8'hA5);
                pkt.push_back(r.opc);
                pkt.push_back({r.wr, m_lost, 2'b00, r.tgt});
                pkt.push_back(r.pc[7:0]);
                pkt.push_back(r.pc[15:8]);
                pkt.push_back(r.pc[23:16]);
                pkt.push_back(r.res[7:0]);
                pkt.push_back(r.res[15:8]);
                pkt.push_back(r.res[23:16]);
                m_lost = 0;
            end
            if (preq && !drp) begin
                r.pc  = wb_pc;
                r.opc = wb_opc;
                r.wr  = wb_wr;
                r.tgt = wb_tgt;
                r.res = wb_res;
                q.push_back(r);
            end
            if (drp) begin
                if (m_drop < 255) m_drop++;
                m_lost = 1;
            end
        end
        @(negedge clk);
        check("valid", {31'd0, tx_valid}, {31'd0, pkt.size() > 0});
        if (pkt.size() > 0) check("data", {24'd0, tx_data}, {24'd0, pkt[0]});
        check("level", 32'(fifo_level), q.size());
        check("drops", {24'd0, drop_cnt}, m_drop);
        check("busy", {31'd0, busy}, {31'd0, busy_m()});
        if (32'(fifo_level) > peak) peak = 32'(fifo_level);
    endtask

    task automatic rand_rec();
        wb_pc  = 24'($urandom);
        wb_opc = 8'($urandom);
        wb_wr  = 1'($urandom);
        wb_tgt = 4'($urandom);
        wb_res = 24'($urandom);
    endtask

    task automatic push_one();
        rand_rec();
        wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && busy_m(); i++) step();
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        exp1 = '{8'hA5, 8'h21, 8'h83, 8'h10, 8'h00, 8'h00, 8'h56, 8'h34, 8'h12};
        rst = 1'b1; en = 1'b1; wb_valid = 1'b0; tx_ready = 1'b1;
        wb_pc = '0; wb_opc = '0; wb_wr = 1'b0; wb_tgt = '0; wb_res = '0;
        m_lost = 0; m_drop = 0; peak = 0;
        @(negedge clk);
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_data", {24'd0, tx_data}, 32'h0);
        check("rst_valid", {31'd0, tx_valid}, 32'd0);

        // Single known record.
        seen.delete();
        wb_pc = 24'h000010; wb_opc = 8'h21; wb_wr = 1'b1;
        wb_tgt = 4'd3; wb_res = 24'h123456; wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
        check("lat_n", {31'd0, tx_valid}, 32'd0);
        step();
        check("lat_n1", {31'd0, tx_valid}, 32'd1);
        drain("single_idle");
        check("single_cnt", seen.size(), 9);
        for (int i = 0; i < 9 && i < seen.size(); i++)
            check($sformatf("single_b%0d", i), {24'd0, seen[i]}, {24'd0, exp1[i]});

        // Ready toggling every cycle.
        seen.delete();
        push_one();
        for (int i = 0; i < 60 && busy_m(); i++) begin
            tx_ready = ~tx_ready;
            step();
        end
        tx_ready = 1'b1;
        drain("toggle_idle");
        check("toggle_cnt", seen.size(), 9);

        // Three back-to-back records.
        peak = 0;
        seen.delete();
        repeat (3) push_one();
        drain("three_idle");
        check("three_peak", peak, 2);
        check("three_cnt", seen.size(), 27);

        // Overflow with a stalled packet in flight.
        tx_ready = 1'b0;
        push_one();
        step();
        check("stall_valid", {31'd0, tx_valid}, 32'd1);
        wb_valid = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            rand_rec();
            step();
        end
        wb_valid = 1'b0;
        check("full_level", 32'(fifo_level), DEPTH);
        check("drop3", {24'd0, drop_cnt}, 32'd3);

        // Pop and push on the same edge while full.
        tx_ready = 1'b1;
        repeat (8) step();
        push_one();
        check("pp_level", 32'(fifo_level), DEPTH);
        check("pp_drop", {24'd0, drop_cnt}, 32'd3);
        drain("overflow_idle");

        // Reset at B4 with two queued.
        repeat (3) push_one();
        for (int i = 0; i < 20 && pkt.size() != 5; i++) step();
        check("pre_rst_q", 32'(fifo_level), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_valid", {31'd0, tx_valid}, 32'd0);
        check("mrst_level", 32'(fifo_level), 32'd0);
        check("mrst_drop", {24'd0, drop_cnt}, 32'd0);
        seen.delete();
        push_one();
        drain("mrst_idle");
        check("mrst_first", seen.size() > 0 ? {24'd0, seen[0]} : 32'hFFFF, 32'hA5);

        // Randomized traffic with varying load and rare resets.
        for (int i = 0; i < 4000; i++) begin
            int load;
            load     = (i / 500) % 4;
            en       = ($urandom_range(0, 9) != 0);
            wb_valid = ($urandom_range(0, 15) < 1 + 4 * load);
            rand_rec();
            tx_ready = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 799) == 0);
            step();
        end
        rst = 1'b0; wb_valid = 1'b0; tx_ready = 1'b1;
        drain("final_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
